pwm_dimmer_multi: RTL

Parametrised N-channel PWM dimmer for LED drive. Each channel holds a saturating brightness level. Per-channel up/down inputs adjust the level at a prescaled step rate. A shared free-running period counter is compared against glitch-free double-buffered duty registers to generate the outputs. Sits between board push-buttons (or a control block) and the LED pins.

---
 rtl/pwm_dimmer_multi_if.sv | 18 +
 rtl/pwm_dimmer_multi.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pwm_dimmer_multi_if.sv
// Bus bundle for pwm_dimmer_multi.
//   up, down      : per-channel adjust requests (driven by master, asynchronous levels)
//   pwm_out       : per-channel PWM outputs
//   period_start  : one-cycle pulse aligned with period counter value 0
//   level         : pending level per channel, channel i at [i*WIDTH +: WIDTH]
interface pwm_dimmer_multi_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned WIDTH    = 16
);
  logic [CHANNELS-1:0]       up;
  logic [CHANNELS-1:0]       down;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_start;
  logic [CHANNELS*WIDTH-1:0] level;

  modport master (output up, output down, input pwm_out, input period_start, input level);
  modport slave  (input up, input down, output pwm_out, output period_start, output level);
endinterface

// File: rtl/pwm_dimmer_multi.sv
// N-channel PWM LED dimmer with saturating per-channel levels and
// double-buffered duty registers.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : pwm_dimmer_multi_if slave (up/down in, pwm_out/period_start/level out)
// Optional build macro PWM_PHASE_STAGGER_EN: channel i compares against the
// period counter offset by i*2^WIDTH/CHANNELS to spread rising edges.
module pwm_dimmer_multi #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 1024,
  parameter int unsigned STEP     = 1
) (
  input logic              clk,
  input logic              rst,
  pwm_dimmer_multi_if.slave bus
);

  localparam int unsigned      PRE_W     = $clog2(PRESCALE);
  localparam int unsigned      SUM_W     = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_LEVEL = '1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [SUM_W-1:0] STEP_X    = SUM_W'(STEP);
  localparam logic [SUM_W-1:0] MAX_X     = SUM_W'(MAX_LEVEL);

  logic [CHANNELS-1:0] up_meta, up_sync;
  logic [CHANNELS-1:0] down_meta, down_sync;
  logic [PRE_W-1:0]    pre_cnt;
  logic                tick_c;
  logic [WIDTH-1:0]    period_cnt;
  logic                period_start_q;

  // Two-flop synchronisers for the asynchronous request levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_meta   <= '0;
      up_sync   <= '0;
      down_meta <= '0;
      down_sync <= '0;
    end else begin
      up_meta   <= bus.up;
      up_sync   <= up_meta;
      down_meta <= bus.down;
      down_sync <= down_meta;
    end
  end

  // Level-adjust rate prescaler, ticks on its last count
  assign tick_c = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (tick_c) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Shared free-running period counter; period_start has pwm_out's latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt     <= '0;
      period_start_q <= 1'b0;
    end else begin
      period_cnt     <= period_cnt + WIDTH'(1);
      period_start_q <= (period_cnt == '0);
    end
  end

  assign bus.period_start = period_start_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
`ifdef PWM_PHASE_STAGGER_EN
    localparam logic [WIDTH-1:0] OFFSET = WIDTH'((64'(i) << WIDTH) / 64'(CHANNELS));
`else
    localparam logic [WIDTH-1:0] OFFSET = '0;
`endif

    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_next_c;
    logic [WIDTH-1:0] active_q;
    logic [WIDTH-1:0] cnt_c;
    logic [SUM_W-1:0] inc_c;
    logic [SUM_W-1:0] dec_c;
    logic             pwm_q;

    assign cnt_c = period_cnt + OFFSET;

    // Saturating step in WIDTH+1 bits; a borrow into the top bit means underflow
    always_comb begin
      inc_c        = {1'b0, level_q} + STEP_X;
      dec_c        = {1'b0, level_q} - STEP_X;
      level_next_c = level_q;
      if (up_sync[i] && !down_sync[i]) begin
        level_next_c = (inc_c > MAX_X) ? MAX_LEVEL : inc_c[WIDTH-1:0];
      end else if (down_sync[i] && !up_sync[i]) begin
        level_next_c = dec_c[WIDTH] ? '0 : dec_c[WIDTH-1:0];
      end
    end

    // Level updates on ticks; duty reloads only at the channel's period end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        level_q  <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (tick_c) begin
          level_q <= level_next_c;
        end
        if (cnt_c == MAX_LEVEL) begin
          active_q <= level_q;
        end
        pwm_q <= (cnt_c < active_q);
      end
    end

    assign bus.pwm_out[i]                = pwm_q;
    assign bus.level[i*WIDTH +: WIDTH]   = level_q;
  end

endmodule
